// File: rtl/uart_pkg.sv
// Shared types, frame constants and the round-robin arbitration helpers
// used by the UART transmit scheduler and its bit shifter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, HOLD} state_t;

  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   MAX_REQ    = 8;

  // One-hot pick of the first requester after last_owner, wrapping at n_req.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         last_owner,
                                                 input int                 n_req);
    logic [MAX_REQ-1:0] pick;
    logic [2:0]         idx;
    pick = '0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (i <= n_req) begin
        idx = 3'((int'(last_owner) + i) % n_req);
        if (pick == '0 && req[idx]) begin
          pick[idx] = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  function automatic logic [2:0] onehot_index(input logic [MAX_REQ-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[3'(i)]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 serialiser: loads a byte on start, holds each bit for CLKS_PER_BIT
// cycles and flags done during the last cycle of the stop bit.
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       TX,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] frame_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [3:0]            bit_idx_reg;
  logic                  active_reg;
  logic                  bit_end;

  // The line is the LSB of the frame register; ones shift in behind the data
  // so the register naturally returns to the idle level.
  assign TX      = frame_reg[0];
  assign bit_end = active_reg && (cnt_reg == CNT_LAST);
  assign done    = bit_end && (bit_idx_reg == IDX_LAST);

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      frame_reg   <= '1;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      active_reg  <= 1'b0;
    end else if (start) begin
      frame_reg   <= {STOP_BIT, data, START_BIT};
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      active_reg  <= 1'b1;
    end else if (active_reg) begin
      if (bit_end) begin
        cnt_reg <= '0;
        if (bit_idx_reg == IDX_LAST) begin
          active_reg <= 1'b0;
        end else begin
          bit_idx_reg <= bit_idx_reg + 4'd1;
          frame_reg   <= {STOP_BIT, frame_reg[FRAME_BITS-1:1]};
        end
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-granular sharing of one UART TX line between N_REQ
// requesters. Optional HOLD revocation is enabled by UART_TX_HOLD_TIMEOUT_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 100,
  parameter int HOLD_TIMEOUT = 2500
) (
  input  logic               CLOCK,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               TX,
  output logic               timeout
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   last_owner_reg, last_owner_next;
  logic               last_reg, last_next;
  logic               start;
  logic               done;
  logic [MAX_REQ-1:0] pick;
  logic [7:0]         lane_data [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane_data[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  assign pick  = rr_pick(MAX_REQ'(req), 3'(last_owner_reg), N_REQ);
  assign grant = grant_reg;
  assign busy  = (state_reg != IDLE);

`ifdef UART_TX_HOLD_TIMEOUT_EN
  localparam int HT_W = $clog2(HOLD_TIMEOUT + 1);

  logic [HT_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic            timeout_reg, timeout_next;

  assign timeout = timeout_reg;

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end
`else
  // A negative timeout is meaningless, so this is the constant 0.
  assign timeout = (HOLD_TIMEOUT < 0);
`endif

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      owner_reg      <= '0;
      last_owner_reg <= IDX_W'(N_REQ - 1);
      last_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      last_reg       <= last_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    last_next       = last_reg;
    start           = 1'b0;
    req_ack         = '0;
`ifdef UART_TX_HOLD_TIMEOUT_EN
    hold_cnt_next   = hold_cnt_reg;
    timeout_next    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (|req) begin
          grant_next = pick[N_REQ-1:0];
          owner_next = IDX_W'(onehot_index(pick));
          state_next = LOAD;
        end
      end
      LOAD: begin
        // A requester that dropped req between grant and capture gets no ack.
        if (req[owner_reg]) begin
          req_ack    = grant_reg;
          start      = 1'b1;
          last_next  = req_last[owner_reg];
          state_next = SEND;
        end else begin
          grant_next = '0;
          state_next = IDLE;
        end
      end
      SEND: begin
        if (done) begin
          if (last_reg) begin
            grant_next      = '0;
            last_owner_next = owner_reg;
            state_next      = IDLE;
          end else begin
            state_next = HOLD;
`ifdef UART_TX_HOLD_TIMEOUT_EN
            hold_cnt_next = '0;
`endif
          end
        end
      end
      HOLD: begin
        if (req[owner_reg]) begin
          state_next = LOAD;
        end
`ifdef UART_TX_HOLD_TIMEOUT_EN
        else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
          if (hold_cnt_next == HT_W'(HOLD_TIMEOUT)) begin
            grant_next      = '0;
            last_owner_next = owner_reg;
            timeout_next    = 1'b1;
            state_next      = IDLE;
          end
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  uart_tx_shifter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_shifter (
    .CLOCK(CLOCK),
    .reset(reset),
    .start(start),
    .data (lane_data[owner_reg]),
    .TX   (TX),
    .done (done)
  );

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a packet-level round-robin model
// predicts the frame sequence, a TX monitor decodes and checks each frame.
module tb_uart_tx_scheduler;

  localparam int N   = 4;
  localparam int CPB = 4;
  localparam int HT  = 10;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } lane_item_t;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         gap;
  } exp_item_t;

  logic           CLOCK = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_last, req_ack, grant;
  logic [8*N-1:0] req_data;
  logic           busy, TX, timeout;

  logic [N-1:0]   drv_req, drv_last, man_req, man_last;
  logic [7:0]     drv_data [N];

  lane_item_t lane_q  [N][$];
  lane_item_t stage_q [N][$];
  exp_item_t  exp_q[$];

  int npass = 0;
  int ntot  = 0;
  int model_last;
  bit mon_en   = 1'b0;
  bit mon_busy = 1'b0;

  always #5 CLOCK = ~CLOCK;

  assign req      = drv_req | man_req;
  assign req_last = drv_last | man_last;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = drv_data[i];
  end

  uart_tx_scheduler #(
    .N_REQ(N), .CLKS_PER_BIT(CPB), .HOLD_TIMEOUT(HT)
  ) dut (
    .CLOCK(CLOCK), .reset(reset), .req(req), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .grant(grant), .busy(busy),
    .TX(TX), .timeout(timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic stage_byte(input int id, input logic [7:0] d, input logic last);
    lane_item_t it;
    it.data = d;
    it.last = last;
    stage_q[id].push_back(it);
  endtask

  task automatic stage_pkt(input int id, input int len);
    for (int b = 0; b < len; b++) stage_byte(id, 8'($urandom), b == len - 1);
  endtask

  // Packet-level round robin: each staged packet is sent whole, the next owner
  // is the first requester after the previous owner that still has packets.
  task automatic model_issue();
    int         p;
    bit         first;
    lane_item_t it;
    exp_item_t  e;
    first = 1'b1;
    for (int i = 0; i < N; i++)
      foreach (stage_q[i][j]) lane_q[i].push_back(stage_q[i][j]);
    while (1) begin
      p = -1;
      for (int k = 1; k <= N; k++)
        if (p < 0 && stage_q[(model_last + k) % N].size() > 0) p = (model_last + k) % N;
      if (p < 0) break;
      do begin
        it     = stage_q[p].pop_front();
        e.id   = p;
        e.data = it.data;
        e.gap  = first ? -1 : 2;
        exp_q.push_back(e);
        first  = 1'b0;
      end while (!it.last);
      model_last = p;
    end
  endtask

  function automatic bit lanes_pending();
    for (int i = 0; i < N; i++) if (lane_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || mon_busy || busy || lanes_pending()) && n < budget) begin
      @(negedge CLOCK);
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
    repeat (3) @(negedge CLOCK);
  endtask

  // Requester driver: presents the head of each lane queue, pops on ack.
  initial begin
    drv_req  = '0;
    drv_last = '0;
    for (int i = 0; i < N; i++) drv_data[i] = 8'h00;
    forever begin
      @(posedge CLOCK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (lane_q[i].size() > 0) begin
          drv_req[i]  = 1'b1;
          drv_data[i] = lane_q[i][0].data;
          drv_last[i] = lane_q[i][0].last;
        end else begin
          drv_req[i]  = 1'b0;
          drv_last[i] = 1'b0;
        end
      end
      @(negedge CLOCK);
      for (int i = 0; i < N; i++)
        if (req_ack[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
    end
  end

  // TX monitor: decodes each frame and compares against the scoreboard.
  initial begin
    exp_item_t  e;
    logic [9:0] fr;
    logic [7:0] rx;
    logic [N-1:0] eg;
    int shape_err, gnt_err, idle_cnt;
    logic prev_tx;
    prev_tx  = 1'b1;
    idle_cnt = 0;
    forever begin
      @(negedge CLOCK);
      if (mon_en && prev_tx && !TX) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(exp_q.size()), 32'd1);
        end else begin
          e  = exp_q.pop_front();
          if (e.gap >= 0) chk("frame_gap", 32'(idle_cnt), 32'(e.gap));
          fr = {1'b1, e.data, 1'b0};
          eg = N'(1) << e.id;
          rx = '0;
          shape_err = 0;
          gnt_err   = 0;
          for (int c = 0; c < 10 * CPB; c++) begin
            if (c > 0) @(negedge CLOCK);
            if (TX !== fr[c / CPB]) shape_err++;
            if (grant !== eg) gnt_err++;
            if ((c % CPB) == CPB / 2 && c / CPB >= 1 && c / CPB <= 8) rx[c / CPB - 1] = TX;
          end
          chk("frame_byte", 32'(rx), 32'(e.data));
          chk("frame_shape", 32'(shape_err), 32'd0);
          chk("frame_grant", 32'(gnt_err), 32'd0);
          $display("frame: requester %0d expected %02h received %02h gap_before %0d",
                   e.id, e.data, rx, idle_cnt);
        end
        idle_cnt = 0;
        prev_tx  = TX;
        mon_busy = 1'b0;
      end else begin
        if (TX) idle_cnt++;
        prev_tx = TX;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, np;
    reset      = 1'b1;
    man_req    = '0;
    man_last   = '0;
    model_last = N - 1;

    repeat (3) @(negedge CLOCK);
    chk("reset_tx", 32'(TX), 32'd1);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_ack", 32'(req_ack), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    @(negedge CLOCK);
    reset = 1'b0;

    // Withdraw: one-cycle request pulse in IDLE.
    @(posedge CLOCK); #2 man_req[2] = 1'b1;
    @(posedge CLOCK); #2 man_req[2] = 1'b0;
    @(negedge CLOCK);
    chk("withdraw_grant", 32'(grant), 32'h4);
    chk("withdraw_ack", 32'(req_ack), 32'd0);
    @(negedge CLOCK);
    chk("withdraw_release", 32'(grant), 32'd0);
    chk("withdraw_tx", 32'(TX), 32'd1);
    chk("withdraw_busy", 32'(busy), 32'd0);

    // Reset during data bit 3 (frame bit 4).
    man_req[1]  = 1'b1;
    man_last[1] = 1'b1;
    n = 0;
    while (TX && n < 20) begin @(negedge CLOCK); n++; end
    chk("rst_frame_started", 32'(TX), 32'd0);
    repeat (17) @(negedge CLOCK);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_tx", 32'(TX), 32'd1);
    chk("rst_async_grant", 32'(grant), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    @(negedge CLOCK);
    reset = 1'b0;
    @(negedge CLOCK);
    chk("rst_regrant", 32'(grant), 32'h2);
    @(posedge CLOCK);
    #1 man_req = '0;
    man_last = '0;
    wait_idle(100);
    model_last = 1;
    mon_en     = 1'b1;

    // Single byte with latency checks.
    stage_byte(0, 8'hA5, 1'b1);
    model_issue();
    @(negedge CLOCK);
    chk("lat_grant_before", 32'(grant), 32'd0);
    @(negedge CLOCK);
    chk("lat_ack", 32'(req_ack), 32'h1);
    chk("lat_grant", 32'(grant), 32'h1);
    chk("lat_busy", 32'(busy), 32'd1);
    @(negedge CLOCK);
    chk("lat_tx_low", 32'(TX), 32'd0);
    chk("lat_ack_single", 32'(req_ack), 32'd0);
    repeat (39) @(negedge CLOCK);
    chk("single_grant_held", 32'(grant), 32'h1);
    @(negedge CLOCK);
    chk("single_grant_released", 32'(grant), 32'd0);
    wait_idle(200);

    // All four requesting persistently, two one-byte packets each.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) stage_byte(i, 8'($urandom), 1'b1);
    model_issue();
    wait_idle(800);

    // Packet lock: requester 1 sends three bytes while requester 2 waits.
    stage_byte(1, 8'h11, 1'b0);
    stage_byte(1, 8'h22, 1'b0);
    stage_byte(1, 8'h33, 1'b1);
    stage_byte(2, 8'h44, 1'b1);
    model_issue();
    wait_idle(400);

    // Randomised rounds.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          np = $urandom_range(1, 2);
          for (int p = 0; p < np; p++) stage_pkt(i, $urandom_range(1, 3));
        end
      end
      model_issue();
      wait_idle(2000);
    end

`ifdef UART_TX_HOLD_TIMEOUT_EN
    begin
      lane_item_t it;
      exp_item_t  e;
      it.data = 8'h3C;
      it.last = 1'b0;
      e.id    = 0;
      e.data  = 8'h3C;
      e.gap   = -1;
      exp_q.push_back(e);
      lane_q[0].push_back(it);
      n = 0;
      while (TX && n < 20) begin @(negedge CLOCK); n++; end
      n = 0;
      while (!timeout && n < 100) begin @(negedge CLOCK); n++; end
      chk("timeout_delay", 32'(n), 32'd50);
      chk("timeout_grant", 32'(grant), 32'd0);
      @(negedge CLOCK);
      chk("timeout_pulse_width", 32'(timeout), 32'd0);
      model_last = 0;
      stage_byte(0, 8'h5A, 1'b1);
      stage_byte(1, 8'hC3, 1'b1);
      model_issue();
      wait_idle(400);
    end
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
